rt_scan_controller: RTL and testbench
=====================================

Name: rt_scan_controller

Overview:
Synthesizable pixel-scan initiator for RTcore. It walks every pixel of a frame in raster order. For each pixel it issues a one-cycle enable with X/Y coordinates, waits for RTcore's ready, and writes the returned pixel into the framebuffer write port with backpressure. It sits between the frame-start logic and the framebuffer, replacing bench-driven stimulus in hardware builds.

Parameters:
H_RES, 640, pixels per line; X runs 0..H_RES-1
V_RES, 480, lines per frame; Y runs 0..V_RES-1
X_W, 10, width of X coordinate
Y_W, 9, width of Y coordinate
PIX_W, 4, width of pixel from RTcore
ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES
TIMEOUT, 65535, maximum cycles spent in WAIT before the pixel is abandoned
ERR_PIX, 4'hF, pixel value written when a pixel times out

Ports:
CLK  in  1  system clock, 50 MHz
RESET_N  in  1  asynchronous active-low reset
START  in  1  one-cycle pulse; starts a frame when in IDLE
CONTINUOUS  in  1  when 1, the next frame starts automatically after FRAME_DONE
RT_ENABLE  out  1  one-cycle request pulse to RTcore
RT_X  out  X_W  current pixel X; stable from ISSUE until the write is accepted
RT_Y  out  Y_W  current pixel Y; same stability rule as RT_X
RT_READY  in  1  RTcore result valid; may be held high while RTcore is idle
RT_PIXEL  in  PIX_W  RTcore result, valid while RT_READY is 1
FB_WE  out  1  framebuffer write request
FB_ADDR  out  ADDR_W  write address, Y*H_RES+X
FB_DATA  out  PIX_W  write data
FB_STALL  in  1  framebuffer not accepting; a write completes on a cycle with FB_WE=1 and FB_STALL=0
BUSY  out  1  high in every state except IDLE
FRAME_DONE  out  1  one-cycle pulse after the last pixel's write is accepted
ERR  out  1  sticky; set on any timeout; cleared only by reset or by a START pulse accepted in IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; RT_X=0, RT_Y=0, FB_ADDR=0, FB_DATA=0; RT_ENABLE=0, FB_WE=0, BUSY=0, FRAME_DONE=0, ERR=0. Reset mid-frame abandons the frame with no further writes.
- IDLE: on START=1, go to ISSUE with X=Y=0 and FB_ADDR=0; clear ERR. START outside IDLE is ignored.
- ISSUE (1 cycle): RT_ENABLE=1. Clear the armed flag and the timeout counter. Go to WAIT.
- WAIT: RT_ENABLE=0.
  - RT_READY=0 sets armed.
  - RT_READY=1 while armed: latch RT_PIXEL into FB_DATA and go to WRITE.
  - RT_READY=1 while not armed is ignored; this rejects the stale ready level held from the previous pixel.
  - Minimum ISSUE-to-WRITE latency is 3 cycles: ISSUE, one WAIT cycle with READY low, one WAIT cycle with READY high.
  - Timeout counter increments each WAIT cycle. On reaching TIMEOUT: FB_DATA=ERR_PIX, ERR=1, go to WRITE.
- WRITE: FB_WE=1 and FB_ADDR/FB_DATA held until FB_STALL=0. On acceptance, advance:
  - if X<H_RES-1: X+1, FB_ADDR+1, go to ISSUE;
  - else X=0; if Y<V_RES-1: Y+1, FB_ADDR+1, go to ISSUE;
  - else (last pixel) go to DONE.
- FB_ADDR is maintained as an incrementing counter (no multiplier) and must always equal Y*H_RES+X.
- DONE (1 cycle): FRAME_DONE=1, X=Y=FB_ADDR=0. If CONTINUOUS=1, go to ISSUE (frame restarts, ERR keeps its value); otherwise go to IDLE. A START pulse during DONE is ignored.
- Exactly one RT_ENABLE pulse per pixel and exactly one accepted write per pixel: H_RES*V_RES of each per frame. There is no Y overflow or wrap past V_RES-1.

Test Plan:
- H_RES=4, V_RES=3. Model RTcore with ready 2 cycles after enable, pixel=(X+Y)&0xF, READY held high when idle -> 12 enables, 12 writes at FB_ADDR 0..11 with data (X+Y); one FRAME_DONE after the write to address 11; BUSY low afterward.
- Model holds READY=1 continuously with no low cycle after ISSUE -> no write is issued; on TIMEOUT=8, write ERR_PIX=0xF to address 0 and set ERR=1.
- FB_STALL=1 for 5 cycles during the write of pixel (3,0) -> FB_WE, FB_ADDR=3 and FB_DATA stay stable for all 5 cycles; no new RT_ENABLE until acceptance; then (0,1) issues at address 4.
- RESET_N low while in WAIT at pixel (2,1) -> all outputs return to reset values in the same cycle; a subsequent START restarts at (0,0) with ERR=0.
- CONTINUOUS=1 with START pulsed during the frame -> the mid-frame START is ignored; after FRAME_DONE the next RT_ENABLE arrives one cycle later at (0,0); 24 writes over two frames.
- Defaults (640x480): the write at X=639,Y=0 is followed by an issue at (0,1) with FB_ADDR=640; the final write goes to FB_ADDR=307199.

Source files
------------

// File: rtl/rt_scan_controller.sv
// rt_scan_controller: raster-order pixel scan initiator for RTcore.
// Walks every pixel of an H_RES x V_RES frame and issues one enable pulse
// per pixel. It waits for a fresh ready from RTcore, then writes the
// returned pixel to the framebuffer and honours write backpressure.
// A pixel whose result never arrives is written as ERR_PIX, and the
// sticky ERR flag is raised.
module rt_scan_controller #(
    parameter int                H_RES   = 640,
    parameter int                V_RES   = 480,
    parameter int                X_W     = 10,
    parameter int                Y_W     = 9,
    parameter int                PIX_W   = 4,
    parameter int                ADDR_W  = 19,
    parameter int                TIMEOUT = 65535,
    parameter logic [PIX_W-1:0]  ERR_PIX = 4'hF
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic              CONTINUOUS,
    output logic              RT_ENABLE,
    output logic [X_W-1:0]    RT_X,
    output logic [Y_W-1:0]    RT_Y,
    input  logic              RT_READY,
    input  logic [PIX_W-1:0]  RT_PIXEL,
    output logic              FB_WE,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic [PIX_W-1:0]  FB_DATA,
    input  logic              FB_STALL,
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic              ERR
);

    // The timeout counter must be able to hold TIMEOUT-1.
    localparam int              CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [X_W-1:0]  X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]  Y_LAST = Y_W'(V_RES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [X_W-1:0]     x_reg, x_next;
    logic [Y_W-1:0]     y_reg, y_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [PIX_W-1:0]   data_reg, data_next;
    logic [CNT_W-1:0]   tcnt_reg, tcnt_next;
    logic               armed_reg, armed_next;
    logic               err_reg, err_next;

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= S_IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            tcnt_reg  <= '0;
            armed_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            tcnt_reg  <= tcnt_next;
            armed_reg <= armed_next;
            err_reg   <= err_next;
        end
    end

    // Next-state, scan advance and state-decoded strobes.
    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        tcnt_next  = tcnt_reg;
        armed_next = armed_reg;
        err_next   = err_reg;
        RT_ENABLE  = 1'b0;
        FB_WE      = 1'b0;
        BUSY       = 1'b1;
        FRAME_DONE = 1'b0;

        case (state_reg)
            S_IDLE: begin
                BUSY = 1'b0;
                if (START) begin
                    state_next = S_ISSUE;
                    x_next     = '0;
                    y_next     = '0;
                    addr_next  = '0;
                    err_next   = 1'b0;
                end
            end

            S_ISSUE: begin
                RT_ENABLE  = 1'b1;
                armed_next = 1'b0;
                tcnt_next  = '0;
                state_next = S_WAIT;
            end

            S_WAIT: begin
                // Only a ready that follows a low cycle belongs to this
                // pixel; a level still held from the last pixel is stale.
                if (RT_READY && armed_reg) begin
                    data_next  = RT_PIXEL;
                    state_next = S_WRITE;
                end else if (tcnt_reg == CNT_LAST) begin
                    data_next  = ERR_PIX;
                    err_next   = 1'b1;
                    state_next = S_WRITE;
                end else begin
                    tcnt_next = tcnt_reg + CNT_W'(1);
                    if (!RT_READY) begin
                        armed_next = 1'b1;
                    end
                end
            end

            S_WRITE: begin
                FB_WE = 1'b1;
                if (!FB_STALL) begin
                    // The raster address is kept as a running count, so it
                    // advances together with X/Y and needs no multiplier.
                    if (x_reg != X_LAST) begin
                        x_next     = x_reg + X_W'(1);
                        addr_next  = addr_reg + ADDR_W'(1);
                        state_next = S_ISSUE;
                    end else begin
                        x_next = '0;
                        if (y_reg != Y_LAST) begin
                            y_next     = y_reg + Y_W'(1);
                            addr_next  = addr_reg + ADDR_W'(1);
                            state_next = S_ISSUE;
                        end else begin
                            state_next = S_DONE;
                        end
                    end
                end
            end

            S_DONE: begin
                FRAME_DONE = 1'b1;
                x_next     = '0;
                y_next     = '0;
                addr_next  = '0;
                state_next = CONTINUOUS ? S_ISSUE : S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign RT_X    = x_reg;
    assign RT_Y    = y_reg;
    assign FB_ADDR = addr_reg;
    assign FB_DATA = data_reg;
    assign ERR     = err_reg;

endmodule

// File: tb/tb_rt_scan_controller.sv
// tb_rt_scan_controller: directed, table-driven bench for rt_scan_controller.
// Instance A is a 4x3 frame with an 8-cycle timeout. Instance B uses the
// default 640x480 geometry to check the line wrap.
module tb_rt_scan_controller;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- instance A (4x3, TIMEOUT=8) ----------------
    logic       a_rst_n, a_start, a_cont, a_en, a_ready, a_we, a_stall;
    logic       a_busy, a_done, a_err;
    logic [2:0] a_x;
    logic [1:0] a_y;
    logic [3:0] a_pixel, a_addr, a_data;

    rt_scan_controller #(
        .H_RES(4), .V_RES(3), .X_W(3), .Y_W(2), .PIX_W(4), .ADDR_W(4),
        .TIMEOUT(8), .ERR_PIX(4'hF)
    ) dut_a (
        .CLK(CLK), .RESET_N(a_rst_n), .START(a_start), .CONTINUOUS(a_cont),
        .RT_ENABLE(a_en), .RT_X(a_x), .RT_Y(a_y), .RT_READY(a_ready),
        .RT_PIXEL(a_pixel), .FB_WE(a_we), .FB_ADDR(a_addr), .FB_DATA(a_data),
        .FB_STALL(a_stall), .BUSY(a_busy), .FRAME_DONE(a_done), .ERR(a_err)
    );

    // ---------------- instance B (default geometry) ----------------
    logic        b_rst_n, b_start, b_cont, b_en, b_ready, b_we, b_stall;
    logic        b_busy, b_done, b_err;
    logic [9:0]  b_x;
    logic [8:0]  b_y;
    logic [3:0]  b_pixel, b_data;
    logic [18:0] b_addr;

    rt_scan_controller dut_b (
        .CLK(CLK), .RESET_N(b_rst_n), .START(b_start), .CONTINUOUS(b_cont),
        .RT_ENABLE(b_en), .RT_X(b_x), .RT_Y(b_y), .RT_READY(b_ready),
        .RT_PIXEL(b_pixel), .FB_WE(b_we), .FB_ADDR(b_addr), .FB_DATA(b_data),
        .FB_STALL(b_stall), .BUSY(b_busy), .FRAME_DONE(b_done), .ERR(b_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // RTcore models: ready drops on enable, returns 2 cycles later with data.
    // Mode 1 of model A holds ready high permanently (never a fresh ready).
    int         a_mode = 0;
    int         a_cnt  = 0;
    logic [3:0] a_px   = 4'd0;
    initial begin
        a_ready = 1'b1;
        a_pixel = 4'd0;
        forever begin
            @(negedge CLK);
            if (a_mode == 1) begin
                a_ready = 1'b1;
                a_cnt   = 0;
            end else if (a_en) begin
                a_ready = 1'b0;
                a_px    = 4'(a_x) + 4'(a_y);
                a_cnt   = 2;
            end else if (a_cnt > 0) begin
                a_cnt--;
                if (a_cnt == 0) begin
                    a_ready = 1'b1;
                    a_pixel = a_px;
                end
            end
        end
    end

    int         b_cnt = 0;
    logic [3:0] b_px  = 4'd0;
    initial begin
        b_ready = 1'b1;
        b_pixel = 4'd0;
        forever begin
            @(negedge CLK);
            if (b_en) begin
                b_ready = 1'b0;
                b_px    = b_x[3:0];
                b_cnt   = 2;
            end else if (b_cnt > 0) begin
                b_cnt--;
                if (b_cnt == 0) begin
                    b_ready = 1'b1;
                    b_pixel = b_px;
                end
            end
        end
    end

    // Monitor for A: accepted writes, enables and frame-done pulses.
    int wr_addr[$];
    int wr_data[$];
    int n_en       = 0;
    int n_done     = 0;
    int wr_at_done = 0;
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (a_rst_n) begin
                if (a_we && !a_stall) begin
                    wr_addr.push_back(int'(a_addr));
                    wr_data.push_back(int'(a_data));
                    $display("write addr=%0d data=%0h", a_addr, a_data);
                end
                if (a_en) n_en++;
                if (a_done) begin
                    n_done++;
                    wr_at_done = wr_addr.size();
                end
            end
        end
    end

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        n_en   = 0;
        n_done = 0;
    endtask

    task automatic pulse_a_start();
        a_start = 1'b1;
        @(negedge CLK);
        a_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        for (int i = 0; i < 400; i++) begin
            @(posedge CLK);
            if (n_done >= target) break;
        end
        @(negedge CLK);
        check(name, (n_done >= target) ? 1 : 0, 1);
    endtask

    typedef struct {
        int x;
        int y;
        int addr;
        int data;
    } vec_t;
    vec_t vecs[12];

    bit found;
    int k;

    initial begin
        // Expected raster of the 4x3 frame: address Y*4+X, data X+Y.
        vecs = '{
            '{0, 0, 0, 0}, '{1, 0, 1, 1}, '{2, 0, 2, 2}, '{3, 0, 3, 3},
            '{0, 1, 4, 1}, '{1, 1, 5, 2}, '{2, 1, 6, 3}, '{3, 1, 7, 4},
            '{0, 2, 8, 2}, '{1, 2, 9, 3}, '{2, 2, 10, 4}, '{3, 2, 11, 5}
        };

        a_rst_n = 1'b0; a_start = 1'b0; a_cont = 1'b0; a_stall = 1'b0;
        b_rst_n = 1'b0; b_start = 1'b0; b_cont = 1'b0; b_stall = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset state.
        check("rst_enable", a_en, 0);
        check("rst_we", a_we, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_err", a_err, 0);
        check("rst_x", a_x, 0);
        check("rst_y", a_y, 0);
        check("rst_addr", a_addr, 0);
        check("rst_data", a_data, 0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        @(negedge CLK);

        // ---- Frame 1: plain scan, minimum latency ----
        clear_mon();
        pulse_a_start();
        check("f1_first_en", a_en, 1);
        check("f1_first_x", a_x, 0);
        check("f1_first_y", a_y, 0);
        check("f1_busy", a_busy, 1);
        @(negedge CLK);
        @(negedge CLK);
        check("f1_no_early_we", a_we, 0);
        @(negedge CLK);
        check("f1_we_at_3", a_we, 1);
        check("f1_data0", a_data, 0);
        wait_done(1, "f1_done_seen");
        check("f1_writes_before_done", wr_at_done, 12);
        check("f1_write_count", wr_addr.size(), 12);
        check("f1_enable_count", n_en, 12);
        check("f1_done_count", n_done, 1);
        for (int i = 0; i < 12; i++) begin
            if (i < wr_addr.size()) begin
                check($sformatf("f1_addr[%0d]", i), wr_addr[i], vecs[i].addr);
                check($sformatf("f1_data[%0d]", i), wr_data[i], vecs[i].data);
            end
        end
        check("f1_busy_after", a_busy, 0);
        check("f1_err_after", a_err, 0);

        // ---- Frame 2: 5-cycle stall on pixel (3,0) ----
        clear_mon();
        pulse_a_start();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (a_we && a_x == 3'd3 && a_y == 2'd0) begin
                found = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        check("st_reach_30", found, 1);
        a_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("st_we_held", a_we, 1);
            check("st_addr_held", a_addr, 3);
            check("st_data_held", a_data, 3);
            check("st_no_enable", a_en, 0);
        end
        a_stall = 1'b0;
        @(negedge CLK);
        check("st_next_en", a_en, 1);
        check("st_next_x", a_x, 0);
        check("st_next_y", a_y, 1);
        check("st_next_addr", a_addr, 4);
        wait_done(1, "st_done_seen");
        check("st_write_count", wr_addr.size(), 12);
        if (wr_addr.size() >= 5) begin
            check("st_addr3", wr_addr[3], 3);
            check("st_addr4", wr_addr[4], 4);
        end

        // ---- Timeout on a permanently held ready ----
        clear_mon();
        a_mode = 1;
        pulse_a_start();
        check("to_issue", a_en, 1);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (a_we) begin
                k = i;
                break;
            end
        end
        check("to_cycles_to_write", k, 9);
        check("to_addr", a_addr, 0);
        check("to_data", a_data, 15);
        check("to_err", a_err, 1);
        #1 a_mode = 0;

        // ---- Reset while waiting on pixel (2,1) ----
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (a_busy && !a_en && !a_we && !a_done && a_x == 3'd2 && a_y == 2'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("rw_reach_21", found, 1);
        check("rw_err_sticky", a_err, 1);
        a_rst_n = 1'b0;
        #1;
        check("rw_enable", a_en, 0);
        check("rw_we", a_we, 0);
        check("rw_busy", a_busy, 0);
        check("rw_done", a_done, 0);
        check("rw_err", a_err, 0);
        check("rw_x", a_x, 0);
        check("rw_y", a_y, 0);
        check("rw_addr", a_addr, 0);
        check("rw_data", a_data, 0);
        @(negedge CLK);
        @(negedge CLK);
        a_rst_n = 1'b1;
        clear_mon();
        repeat (5) @(negedge CLK);
        check("rw_no_writes", wr_addr.size(), 0);
        pulse_a_start();
        check("rw_restart_en", a_en, 1);
        check("rw_restart_x", a_x, 0);
        check("rw_restart_y", a_y, 0);
        check("rw_restart_err", a_err, 0);
        wait_done(1, "rw_done_seen");
        check("rw_write_count", wr_addr.size(), 12);

        // ---- Continuous: two frames, mid-frame START ignored ----
        clear_mon();
        a_cont = 1'b1;
        pulse_a_start();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (a_en && a_x == 3'd1 && a_y == 2'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("ct_reach_11", found, 1);
        pulse_a_start();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (a_done) begin
                found = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        check("ct_first_done", found, 1);
        @(negedge CLK);
        check("ct_restart_en", a_en, 1);
        check("ct_restart_x", a_x, 0);
        check("ct_restart_y", a_y, 0);
        check("ct_restart_addr", a_addr, 0);
        a_cont = 1'b0;
        wait_done(2, "ct_second_done");
        check("ct_write_count", wr_addr.size(), 24);
        check("ct_enable_count", n_en, 24);
        if (wr_addr.size() == 24) begin
            check("ct_addr11", wr_addr[11], 11);
            check("ct_addr12", wr_addr[12], 0);
            check("ct_addr23", wr_addr[23], 11);
        end
        @(negedge CLK);
        check("ct_busy_after", a_busy, 0);

        // ---- Default geometry: wrap from (639,0) to (0,1) ----
        b_start = 1'b1;
        @(negedge CLK);
        b_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK);
            if (b_we && b_addr == 19'd639) begin
                found = 1'b1;
                break;
            end
        end
        check("b_reach_639", found, 1);
        check("b_last_x", b_x, 639);
        check("b_last_y", b_y, 0);
        check("b_last_data", b_data, 15);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (b_en) begin
                found = 1'b1;
                break;
            end
        end
        check("b_wrap_en", found, 1);
        check("b_wrap_x", b_x, 0);
        check("b_wrap_y", b_y, 1);
        check("b_wrap_addr", b_addr, 640);
        check("b_no_done", b_done, 0);
        b_rst_n = 1'b0;
        @(negedge CLK);
        check("b_rst_busy", b_busy, 0);
        check("b_rst_err", b_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
